// File: rtl/audio_in_buffer.sv
// audio_in_buffer: multi-channel interleaved input sample memory.
// Samples arrive channel-interleaved on a valid/ready handshake and are stored
// one address per frame, one RAM bank per channel. Reads are relative to the
// newest complete frame. Reset or clear zero-fills every bank with a timed sweep.
module audio_in_buffer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CH_W     = 1
) (
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              clear,
    input  logic              circ_mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [CH_W-1:0]   ch_idx,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [ADDR_W-1:0] rd_index,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DepthCnt  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] SweepLast = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   LastCh    = CH_W'(CHANNELS - 1);

    typedef enum logic {StClear, StRun} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   sweep_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [CH_W-1:0]     ch_idx_q;
    logic [ADDR_W:0]     count_q;
    logic                overflow_q;
    logic                rd_valid_q;
    logic [CH_W-1:0]     rd_ch_q;

    logic                restart;
    logic                running;
    logic                clearing;
    logic                accept;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   bank_rd [CHANNELS];

    // Reset and clear share one restart path; clear beats a simultaneous handshake.
    assign restart  = ~Reset_n | clear;
    assign running  = (state_q == StRun);
    assign clearing = (state_q == StClear);
    assign full     = (count_q == DepthCnt);
    assign in_ready = running & (circ_mode | ~full);
    assign accept   = in_valid & in_ready & ~restart;
    assign busy     = clearing;
    assign wr_ptr   = wr_ptr_q;
    assign ch_idx   = ch_idx_q;
    assign count    = count_q;
    assign overflow = overflow_q;

    // History is addressed from the last complete frame, so a half-written frame stays hidden.
    assign rd_addr = wr_ptr_q - ADDR_W'(1) - rd_index;
    assign wr_addr = clearing ? sweep_q : wr_ptr_q;
    assign wr_data = clearing ? '0 : in_data;

    // Control FSM: sweep sequencing, frame/channel pointers, fill level and overflow flag.
    always_ff @(posedge Sclk) begin
        if (restart) begin
            state_q    <= StClear;
            sweep_q    <= '0;
            wr_ptr_q   <= '0;
            ch_idx_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= running;
            case (state_q)
                StClear: begin
                    sweep_q <= sweep_q + ADDR_W'(1);
                    if (sweep_q == SweepLast) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (in_valid && !circ_mode && full) begin
                        overflow_q <= 1'b1;
                    end
                    if (accept) begin
                        if (ch_idx_q == LastCh) begin
                            ch_idx_q <= '0;
                            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                            if (!full) begin
                                count_q <= count_q + (ADDR_W+1)'(1);
                            end
                        end else begin
                            ch_idx_q <= ch_idx_q + CH_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Track which bank the pending registered read belongs to.
    always_ff @(posedge Sclk) begin
        rd_ch_q <= rd_ch;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;
        logic              we;

        assign we = clearing | (accept & (ch_idx_q == CH_W'(c)));

        // Simple dual-port RAM: one write port, one registered read port (old data on collision).
        always_ff @(posedge Sclk) begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            rd_q <= mem[rd_addr];
        end

        assign bank_rd[c] = rd_q;
    end

    // Select the addressed bank; out-of-range channels and sweep/reset cycles read as zero.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_valid_q && rd_ch_q == CH_W'(c)) begin
                rd_data = bank_rd[c];
            end
        end
    end

endmodule

// File: tb/tb_audio_in_buffer.sv
// Directed bench for audio_in_buffer: sweep timing, stereo framing, history
// reads, linear overflow, circular wrap and clear restarts.
module tb_audio_in_buffer;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 512;
    localparam int ADDR_W   = 9;
    localparam int CHANNELS = 2;
    localparam int CH_W     = 1;

    logic              Sclk = 1'b0;
    logic              Reset_n;
    logic              clear;
    logic              circ_mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [CH_W-1:0]   ch_idx;
    logic [CH_W-1:0]   rd_ch;
    logic [ADDR_W-1:0] rd_index;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              overflow;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string             name;
        logic [CH_W-1:0]   ch;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [9];

    always #5 Sclk = ~Sclk;

    audio_in_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) dut (
        .Sclk      (Sclk),
        .Reset_n   (Reset_n),
        .clear     (clear),
        .circ_mode (circ_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ch_idx    (ch_idx),
        .rd_ch     (rd_ch),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .wr_ptr    (wr_ptr),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_sample(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic write_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        write_sample(l);
        write_sample(r);
    endtask

    task automatic rd_check(input string name, input logic [CH_W-1:0] ch,
                            input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] exp);
        rd_ch    = ch;
        rd_index = idx;
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic sweep_len(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
            if (n == 100) check({name, "_mid_read"}, 32'(rd_data), 32'h0);
        end
        check(name, n, 512);
    endtask

    initial begin
        vecs[0] = '{"st_l0",   1'd0, 9'd0,   16'h1009};
        vecs[1] = '{"st_r9",   1'd1, 9'd9,   16'h2000};
        vecs[2] = '{"st_l9",   1'd0, 9'd9,   16'h1000};
        vecs[3] = '{"st_r0",   1'd1, 9'd0,   16'h2009};
        vecs[4] = '{"st_l5",   1'd0, 9'd5,   16'h1004};
        vecs[5] = '{"st_r3",   1'd1, 9'd3,   16'h2006};
        vecs[6] = '{"st_l10",  1'd0, 9'd10,  16'h0000};
        vecs[7] = '{"st_l200", 1'd0, 9'd200, 16'h0000};
        vecs[8] = '{"st_r1",   1'd1, 9'd1,   16'h2008};

        Reset_n   = 1'b0;
        clear     = 1'b0;
        circ_mode = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rd_ch     = '0;
        rd_index  = 9'd5;

        tick();
        tick();
        check("rst_busy",     32'(busy), 1);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_count",    32'(count), 0);
        check("rst_wr_ptr",   32'(wr_ptr), 0);
        check("rst_ch_idx",   32'(ch_idx), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_rd_data",  32'(rd_data), 0);

        Reset_n = 1'b1;
        sweep_len("rst_sweep_len");
        check("run_in_ready", 32'(in_ready), 1);
        rd_check("run_read_zero", 1'd1, 9'd300, 16'h0000);

        // Ten stereo frames.
        for (int n = 0; n < 10; n++) begin
            write_frame(16'(32'h1000 + n), 16'(32'h2000 + n));
        end
        check("st_count",  32'(count), 10);
        check("st_wr_ptr", 32'(wr_ptr), 10);
        check("st_ch_idx", 32'(ch_idx), 0);
        for (int i = 0; i < 9; i++) begin
            rd_check(vecs[i].name, vecs[i].ch, vecs[i].idx, vecs[i].exp);
        end

        // Half a frame stays invisible until its last channel lands.
        write_sample(16'h1111);
        check("part_ch_idx", 32'(ch_idx), 1);
        check("part_wr_ptr", 32'(wr_ptr), 10);
        rd_check("part_rd_l", 1'd0, 9'd0, 16'h1009);
        rd_check("part_rd_r", 1'd1, 9'd0, 16'h2009);
        write_sample(16'h2222);
        check("part_done_wr_ptr", 32'(wr_ptr), 11);
        check("part_done_count",  32'(count), 11);
        check("part_done_ch_idx", 32'(ch_idx), 0);
        rd_check("part_done_rd", 1'd0, 9'd0, 16'h1111);

        // Read and write hit address 11 in the same cycle: old data returned.
        rd_ch    = 1'd0;
        rd_index = 9'd511;
        write_sample(16'h3333);
        check("collide_old", 32'(rd_data), 32'h0);
        write_sample(16'h4444);
        check("collide_wr_ptr", 32'(wr_ptr), 12);

        // Clear wins over a simultaneous handshake.
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h5555;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_busy",     32'(busy), 1);
        check("clr_wr_ptr",   32'(wr_ptr), 0);
        check("clr_count",    32'(count), 0);
        check("clr_ch_idx",   32'(ch_idx), 0);
        check("clr_overflow", 32'(overflow), 0);
        for (int i = 0; i < 199; i++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sweep_len("clr_restart_len");
        rd_check("clr_dropped", 1'd0, 9'd511, 16'h0000);
        rd_check("clr_wiped",   1'd1, 9'd0,   16'h0000);

        // Linear fill to full, then one more offer.
        circ_mode = 1'b0;
        for (int n = 0; n < 512; n++) begin
            write_frame(16'(32'h4000 + n), 16'(32'h8000 + n));
        end
        check("lin_count",    32'(count), 512);
        check("lin_full",     32'(full), 1);
        check("lin_in_ready", 32'(in_ready), 0);
        check("lin_wr_ptr",   32'(wr_ptr), 0);
        check("lin_ovf_pre",  32'(overflow), 0);
        write_sample(16'hDEAD);
        check("lin_overflow", 32'(overflow), 1);
        check("lin_count2",   32'(count), 512);
        check("lin_ch_idx",   32'(ch_idx), 0);
        rd_check("lin_rd_newest_l", 1'd0, 9'd0,   16'h41FF);
        rd_check("lin_rd_newest_r", 1'd1, 9'd0,   16'h81FF);
        rd_check("lin_rd_oldest",   1'd0, 9'd511, 16'h4000);
        check("lin_ovf_sticky", 32'(overflow), 1);

        // Circular wrap: three more frames over the full buffer.
        circ_mode = 1'b1;
        #1;
        check("circ_in_ready", 32'(in_ready), 1);
        for (int n = 512; n < 515; n++) begin
            write_frame(16'(32'h4000 + n), 16'(32'h8000 + n));
        end
        check("circ_wr_ptr", 32'(wr_ptr), 3);
        check("circ_count",  32'(count), 512);
        rd_check("circ_rd0",   1'd0, 9'd0,   16'h4202);
        rd_check("circ_rd511", 1'd0, 9'd511, 16'h4003);
        rd_check("circ_rd_r1", 1'd1, 9'd1,   16'h8201);
        check("circ_ovf_kept", 32'(overflow), 1);

        // Back to linear while full: acceptance stops, contents kept.
        circ_mode = 1'b0;
        #1;
        check("lin2_in_ready", 32'(in_ready), 0);
        write_sample(16'hBEEF);
        check("lin2_wr_ptr", 32'(wr_ptr), 3);
        check("lin2_ch_idx", 32'(ch_idx), 0);
        rd_check("lin2_kept", 1'd1, 9'd2, 16'h8200);

        // Reset from RUN clears the sticky flag.
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        check("rst2_overflow", 32'(overflow), 0);
        check("rst2_busy",     32'(busy), 1);
        check("rst2_count",    32'(count), 0);
        check("rst2_rd_data",  32'(rd_data), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
